mux4_rr_arbiter: RTL

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

---
 rtl/mux4_arb_if.sv | 9 +
 rtl/mux4_rr_arbiter.sv | 66 ++++++
 2 files changed

// File: rtl/mux4_arb_if.sv
// mux4_arb_if: request, data and grant bundle between the sources and mux4_rr_arbiter
interface mux4_arb_if;
   logic [3:0] req;
   logic       i0, i1, i2, i3;
   logic [3:0] gnt;
   logic       s1, s0, y, busy;
   modport master (output req, i0, i1, i2, i3, input gnt, s1, s0, y, busy);
   modport slave  (input req, i0, i1, i2, i3, output gnt, s1, s0, y, busy);
endinterface

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: 4-source round-robin arbiter driving a registered 4:1 channel mux
// Optional hold timeout enabled by defining MUX4_ARB_TIMEOUT_EN (limit set by HOLD_MAX)
module mux4_rr_arbiter #(
   parameter int HOLD_MAX = 8
) (
   input logic       clk,
   input logic       rst_n,
   mux4_arb_if.slave bus
);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t     state;
   logic [3:0] gnt, cand, din, cur_oh;
   logic [1:0] sel, ptr, win;
   logic       y, busy, tmo, keep;

   assign din    = {bus.i3, bus.i2, bus.i1, bus.i0};
   assign cur_oh = 4'b0001 << sel;
   assign keep   = (state == GRANT) && bus.req[sel] && !tmo;
   // at timeout the current holder is excluded so another requester wins
   assign cand   = bus.req & ~(tmo ? cur_oh : 4'b0000);

   always_comb begin
      win = ptr;
      for (int j = 3; j >= 0; j--)
         if (cand[ptr + 2'(j)]) win = ptr + 2'(j);
   end

`ifdef MUX4_ARB_TIMEOUT_EN
   logic [7:0] cnt;
   assign tmo = (state == GRANT) && (cnt == 8'(HOLD_MAX - 1));
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= 8'd0;
      else cnt <= keep ? cnt + 8'd1 : 8'd0;
`else
   assign tmo = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         gnt   <= 4'b0000;
         sel   <= 2'd0;
         ptr   <= 2'd0;
         y     <= 1'b0;
         busy  <= 1'b0;
      end else begin
         y <= (state == GRANT) ? din[sel] : 1'b0;
         if (!keep && |cand) begin
            state <= GRANT;
            gnt   <= 4'b0001 << win;
            sel   <= win;
            ptr   <= win + 2'd1;
            busy  <= 1'b1;
         end else if (!keep && !(state == GRANT && bus.req[sel])) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            busy  <= 1'b0;
         end
      end

   assign bus.gnt  = gnt;
   assign bus.s1   = sel[1];
   assign bus.s0   = sel[0];
   assign bus.y    = y;
   assign bus.busy = busy;
endmodule
